// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for the FIR MAC: captures one sample into a circular delay line,
// then streams taps_p (sample, coefficient) operand pairs flagged with first/last.
module fir_tap_sequencer #(
    parameter int width_p = 12,
    parameter int taps_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      coef_we_i,
    input  logic [$clog2(taps_p)-1:0] coef_addr_i,
    input  logic [width_p-1:0]        coef_data_i,
    output logic                      busy_o,
    output logic [width_p-1:0]        sample_o,
    output logic [width_p-1:0]        coef_o,
    output logic                      first_o,
    output logic                      last_o,
    output logic                      valid_o,
    input  logic                      ready_i
);
    localparam int AddrW = $clog2(taps_p);
    localparam logic [AddrW-1:0] LastK = AddrW'(taps_p - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [AddrW-1:0]   wrPtr_q, wrPtr_d;
    logic [AddrW-1:0]   k_q, k_d;
    logic [AddrW-1:0]   rdIdx;
    logic [width_p-1:0] delayLine_q [taps_p];
    logic [width_p-1:0] coef_q [taps_p];
    logic               sampleWe;
    logic               coefWe;
    logic               transfer;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            k_q     <= k_d;
        end
    end

    // Both arrays clear on reset so an abandoned sequence leaves no stale history.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < taps_p; i++) begin
                delayLine_q[i] <= '0;
                coef_q[i]      <= '0;
            end
        end else begin
            if (sampleWe) begin
                delayLine_q[wrPtr_q] <= data_i;
            end
            if (coefWe) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wrPtr_d  = wrPtr_q;
        k_d      = k_q;
        sampleWe = 1'b0;
        coefWe   = 1'b0;
        transfer = 1'b0;
        ready_o  = 1'b0;
        busy_o   = 1'b0;
        valid_o  = 1'b0;
        first_o  = 1'b0;
        last_o   = 1'b0;
        sample_o = '0;
        coef_o   = '0;
        rdIdx    = wrPtr_q - k_q;

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                coefWe  = coef_we_i;
                if (valid_i) begin
                    sampleWe = 1'b1;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                valid_o  = 1'b1;
                busy_o   = 1'b1;
                sample_o = delayLine_q[rdIdx];
                coef_o   = coef_q[k_q];
                first_o  = (k_q == '0);
                last_o   = (k_q == LastK);
                transfer = ready_i;
                // The write pointer only moves once the whole sequence has drained,
                // so every pair of the sequence indexes relative to the new sample.
                if (transfer) begin
                    if (k_q == LastK) begin
                        wrPtr_d = wrPtr_q + 1'b1;
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: a sample-history model predicts every
// operand pair, and a negedge monitor pops and compares each transferred pair.
module tb_fir_tap_sequencer;
    localparam int W  = 12;
    localparam int T  = 16;
    localparam int AW = 4;
    localparam int HW = 2 * W + 3;

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         f;
        logic         l;
    } pair_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          coef_we_i = 1'b0;
    logic [AW-1:0] coef_addr_i = '0;
    logic [W-1:0]  coef_data_i = '0;
    logic          busy_o;
    logic [W-1:0]  sample_o;
    logic [W-1:0]  coef_o;
    logic          first_o;
    logic          last_o;
    logic          valid_o;
    logic          ready_i = 1'b1;

    pair_t         expQ[$];
    logic [W-1:0]  history[$];
    logic [W-1:0]  coefModel[T];
    int            compared = 0;
    int            mismatched = 0;
    bit            modelBusy = 1'b0;
    bit            monitorEn = 1'b0;
    bit            randomReady = 1'b0;
    bit            stallPrev = 1'b0;
    logic [HW-1:0] heldOut = '0;

    fir_tap_sequencer #(.width_p(W), .taps_p(T)) dut (
        .clk_i(clock),
        .reset_i(reset),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .coef_we_i(coef_we_i),
        .coef_addr_i(coef_addr_i),
        .coef_data_i(coef_data_i),
        .busy_o(busy_o),
        .sample_o(sample_o),
        .coef_o(coef_o),
        .first_o(first_o),
        .last_o(last_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready toggles at posedge+1 so it is stable across the following negedge sample.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            ready_i = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: the expected pair for sequence position k is the k-th most recent sample.
    initial begin
        pair_t e;
        forever begin
            @(negedge clock);
            if (monitorEn) begin
                if (modelBusy) begin
                    checkOutput("run_valid", 32'(valid_o), 32'd1);
                    checkOutput("run_ready", 32'(ready_o), 32'd0);
                    checkOutput("run_busy", 32'(busy_o), 32'd1);
                end else begin
                    checkOutput("idle_valid", 32'(valid_o), 32'd0);
                    checkOutput("idle_ready", 32'(ready_o), 32'd1);
                end
                if (stallPrev) begin
                    checkOutput("stall_hold", 32'({valid_o, sample_o, coef_o, first_o, last_o}), 32'(heldOut));
                end
                if (valid_o && ready_i) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_pair", 32'(sample_o), 32'hFFFF_FFFF);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("pair_sample", 32'(sample_o), 32'(e.s));
                        checkOutput("pair_coef", 32'(coef_o), 32'(e.c));
                        checkOutput("pair_first", 32'(first_o), 32'(e.f));
                        checkOutput("pair_last", 32'(last_o), 32'(e.l));
                        if (e.l) modelBusy = 1'b0;
                    end
                end
                stallPrev = valid_o && !ready_i;
                heldOut   = {valid_o, sample_o, coef_o, first_o, last_o};
            end
        end
    end

    task automatic waitIdle();
        int guard = 0;
        while (modelBusy && guard < 400) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (modelBusy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, expected idle", guard);
            modelBusy = 1'b0;
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] x, input bit we,
                                 input logic [AW-1:0] a, input logic [W-1:0] cd);
        waitIdle();
        valid_i     = 1'b1;
        data_i      = x;
        coef_we_i   = we;
        coef_addr_i = a;
        coef_data_i = cd;
        @(posedge clock);
        if (we) coefModel[a] = cd;
        history.push_front(x);
        if (history.size() > T) void'(history.pop_back());
        for (int k = 0; k < T; k++) begin
            expQ.push_back('{s: (k < history.size()) ? history[k] : '0,
                             c: coefModel[k], f: (k == 0), l: (k == T - 1)});
        end
        modelBusy = 1'b1;
        #1;
        valid_i   = 1'b0;
        coef_we_i = 1'b0;
    endtask

    task automatic writeCoef(input logic [AW-1:0] a, input logic [W-1:0] cd);
        bit takes;
        takes       = !modelBusy;
        coef_we_i   = 1'b1;
        coef_addr_i = a;
        coef_data_i = cd;
        @(posedge clock);
        if (takes) coefModel[a] = cd;
        #1;
        coef_we_i = 1'b0;
    endtask

    task automatic doReset();
        monitorEn = 1'b0;
        reset     = 1'b1;
        expQ.delete();
        history.delete();
        for (int i = 0; i < T; i++) coefModel[i] = '0;
        modelBusy = 1'b0;
        stallPrev = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_first_last", 32'({first_o, last_o}), 32'd0);
        checkOutput("rst_sample", 32'(sample_o), 32'd0);
        checkOutput("rst_coef", 32'(coef_o), 32'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        monitorEn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < T; i++) coefModel[i] = '0;
        $display("[TB] starting fir_tap_sequencer bench");
        doReset();

        // Impulse response with coef[k] = k+1
        for (int k = 0; k < T; k++) writeCoef(AW'(k), W'(k + 1));
        applyStimulus(W'(1024), 1'b0, '0, '0);
        for (int m = 1; m < T; m++) applyStimulus('0, 1'b0, '0, '0);

        // Ordering from a clean delay line
        waitIdle();
        doReset();
        for (int k = 0; k < T; k++) writeCoef(AW'(k), W'(k + 1));
        for (int v = 1; v <= 3; v++) applyStimulus(W'(v), 1'b0, '0, '0);

        // Wrap-around: 40 samples, pointer wraps twice
        for (int v = 1; v <= 40; v++) applyStimulus(W'(v), 1'b0, '0, '0);

        // Coefficient write while busy is dropped, while idle takes effect
        applyStimulus(W'(77), 1'b0, '0, '0);
        writeCoef('0, W'(-2048));
        applyStimulus(W'(78), 1'b0, '0, '0);
        waitIdle();
        writeCoef('0, W'(-2048));
        applyStimulus(W'(79), 1'b0, '0, '0);
        applyStimulus(W'(80), 1'b1, AW'(1), W'(-5));

        // Randomised backpressure, samples and coefficient writes
        randomReady = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) waitIdle();
            if ($urandom_range(0, 2) == 0) writeCoef(AW'($urandom), W'($urandom));
            applyStimulus(W'($urandom), 1'($urandom_range(0, 1)), AW'($urandom), W'($urandom));
        end
        waitIdle();
        randomReady = 1'b0;

        // Reset in the middle of a sequence at k = 7
        applyStimulus(W'(300), 1'b0, '0, '0);
        repeat (7) @(posedge clock);
        #1;
        checkOutput("pre_reset_valid", 32'(valid_o), 32'd1);
        doReset();
        applyStimulus(W'(5), 1'b0, '0, '0);

        waitIdle();
        repeat (3) @(posedge clock);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Upstream feeder for the multiply-accumulate stage of the tuner's FIR filter. Accepts one input sample per handshake, stores it in a circular delay line of `taps_p` samples, then streams `taps_p` (sample, coefficient) operand pairs to the MAC over a valid/ready interface. It flags the first and last pair of each output so downstream logic can clear the accumulator and capture the result. Coefficients are held in a register file that software loads through a simple write port.

## Interface
- `width_p`, 12, sample and coefficient width: signed fixed point Q1.11, matching the MAC operand format.
- `taps_p`, 16, number of filter taps. Must be a power of two, at least 2.
- `clk_i`  in  1  single clock; all state is on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `data_i`  in  width_p  signed input sample.
- `valid_i`  in  1  input sample valid.
- `ready_o`  out  1  sequencer can accept a sample (high only in IDLE).
- `coef_we_i`  in  1  coefficient write strobe.
- `coef_addr_i`  in  $clog2(taps_p)  coefficient index k.
- `coef_data_i`  in  width_p  signed coefficient value.
- `busy_o`  out  1  high in RUN state. Coefficient writes are dropped while high.
- `sample_o`  out  width_p  delayed sample x[n-k], goes to MAC `a_i`.
- `coef_o`  out  width_p  coefficient h[k], goes to MAC `b_i`.
- `first_o`  out  1  high with the pair where k=0.
- `last_o`  out  1  high with the pair where k=taps_p-1.
- `valid_o`  out  1  operand pair valid.
- `ready_i`  in  1  MAC ready for the next pair.

## Operation
- **State.** Two-state FSM: IDLE and RUN. Registers:
  - `wr_ptr`, `$clog2(taps_p)` bits: slot where the next sample is written.
  - `k`, tap counter.
  - delay line `buf[taps_p]`.
  - coefficient file `coef[taps_p]`.
- **Reset.** While `reset_i` is high, regardless of clock:
  - state=IDLE, `wr_ptr`=0, `k`=0, every `buf` entry=0, every `coef` entry=0.
  - Outputs: `valid_o`=0, `busy_o`=0, `first_o`=0, `last_o`=0, `ready_o`=1.
  - `sample_o`, `coef_o` = 0.
- **IDLE.**
  - `ready_o`=1, `valid_o`=0.
  - When `valid_i` is high, write `buf[wr_ptr]`=`data_i`, set `k`=0, and go to RUN. `wr_ptr` is not yet advanced.
- **RUN.**
  - `valid_o`=1, `busy_o`=1, `ready_o`=0.
  - `sample_o` = `buf[(wr_ptr - k) mod taps_p]`.
  - `coef_o` = `coef[k]`.
  - `first_o` = (k==0). `last_o` = (k==taps_p-1).
- **Output handshake.** A transfer occurs when `valid_o` and `ready_i` are both high.
  - On a transfer with k<taps_p-1: k increments.
  - On a transfer with k=taps_p-1: `wr_ptr` increments (wrapping modulo taps_p), k=0, state returns to IDLE.
- **Stall.** While `valid_o`=1 and `ready_i`=0, all outputs hold stable. k and the arrays do not change.
- **Coefficient writes.**
  - In IDLE, `coef_we_i` writes `coef[coef_addr_i]`=`coef_data_i` at the clock edge.
  - In RUN, the write is ignored.
  - A write in the same IDLE cycle as a sample acceptance takes effect. The new coefficient is used by that sample's pairs.
- **Arithmetic.** No arithmetic on data. Values pass through bit-exact. Pointer arithmetic wraps modulo taps_p, using natural wrap of the power-of-two width.
- **Unused inputs.** `valid_i` is ignored in RUN. Upstream must hold its sample until `ready_o` is high.

## Timing
- **Latency.** Sample accepted at edge t. The first pair (k=0, `sample_o` = the new sample) is valid in the cycle after edge t.
- **Throughput.** With `ready_i` held high, one sample is processed per taps_p+1 cycles: taps_p pair cycles plus one IDLE cycle.
- **Output logic.** Combinational from registered state and arrays. There is no path from `ready_i` to `valid_o`.
- **`ready_o`.** Depends only on state. There is no combinational path from `valid_i`.
- **Reset mid-RUN.** All outputs drop immediately to their reset values. The in-flight sequence is abandoned, and the delay line and coefficients are cleared.

## Test plan
- **Impulse response.** Load `coef[k]`=k+1. Send sample 1024, then 15 zeros. Required: for input m, the pair with k=m carries `sample_o`=1024 and `coef_o`=m+1; every other pair carries `sample_o`=0. `first_o`/`last_o` are correct on every sequence.
- **Ordering.** Send samples 1, 2, 3. On the third sequence, required pairs are (3, c0), (2, c1), (1, c2), then (0, c3..c15).
- **Backpressure.** Toggle `ready_i` randomly with 50% duty. Required: no pair is lost or duplicated, outputs are stable during stalls, and `ready_o` stays 0 until the last transfer.
- **Wrap-around.** Send 40 samples with values 1..40 (taps_p=16). On sample 40, required `sample_o` sequence is 40, 39, …, 25. `wr_ptr` has wrapped twice.
- **Coefficient write during RUN.** Write `coef[0]`=-2048 while `busy_o`=1. Required: the write is dropped and the next sequence still shows the old `coef[0]`. The same write in IDLE does take effect.
- **Reset mid-RUN.** Assert `reset_i` at k=7. Required: `valid_o`=0 immediately, and `ready_o`=1. A subsequent sample 5 yields (5, 0) followed by all-zero pairs.
